// File: rtl/mem_pkg.sv
// Shared constants and helpers for the main-memory initiator.
// Contents:
//   DATA_W / ADDR_W / DEPTH / READ_LATENCY / LEN_W  - port and memory geometry
//   IDLE, WRITE, READ, DRAIN, ERR                  - FSM state encodings
//   range_err()                                    - request bounds check
package mem_pkg;

  localparam int DATA_W       = 16;
  localparam int ADDR_W       = 16;
  localparam int DEPTH        = 512;
  localparam int READ_LATENCY = 1;
  localparam int LEN_W        = 8;

  // DEPTH widened by one bit so address + length sums cannot overflow.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WRITE = 3'd1;
  localparam logic [2:0] READ  = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] ERR   = 3'd4;

  // A request is rejected when its start address lies outside memory, or
  // when a read burst would run past the last word. Addresses never wrap.
  function automatic logic range_err(input logic              write,
                                     input logic [ADDR_W-1:0] addr,
                                     input logic [LEN_W-1:0]  len);
    logic [ADDR_W:0] start;
    logic [ADDR_W:0] finish;
    start  = {1'b0, addr};
    finish = start + {{(ADDR_W + 1 - LEN_W){1'b0}}, len} + {{ADDR_W{1'b0}}, 1'b1};
    return (start >= DEPTH_EXT) || (!write && (finish > DEPTH_EXT));
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-tag pipeline: a READ_LATENCY-deep shift register of {valid, last}
// tags that tracks read addresses in flight so the response flags line up
// with the memory's registered read data.
// Ports:
//   clock, reset         - system clock, synchronous active-high reset
//   in_valid, in_last    - tag for the address presented this cycle
//   out_valid, out_last  - tag aligned with mem_val this cycle
//   empty                - no tags behind the output stage; once the output
//                          beat is consumed the pipeline is drained
module mem_rd_pipe
  import mem_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic in_valid,
  input  logic in_last,
  output logic out_valid,
  output logic out_last,
  output logic empty
);

  logic [READ_LATENCY-1:0] valid_reg;
  logic [READ_LATENCY-1:0] last_reg;
  logic [READ_LATENCY-1:0] valid_next;
  logic [READ_LATENCY-1:0] last_next;

  generate
    for (genvar gi = 0; gi < READ_LATENCY; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign valid_next[gi] = in_valid;
        assign last_next[gi]  = in_valid & in_last;
      end else begin : g_tail
        assign valid_next[gi] = valid_reg[gi-1];
        assign last_next[gi]  = last_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_reg <= '0;
      last_reg  <= '0;
    end else begin
      valid_reg <= valid_next;
      last_reg  <= last_next;
    end
  end

  assign out_valid = valid_reg[READ_LATENCY-1];
  assign out_last  = last_reg[READ_LATENCY-1];

  generate
    if (READ_LATENCY == 1) begin : g_empty_single
      assign empty = 1'b1;
    end else begin : g_empty_multi
      assign empty = ~|valid_reg[READ_LATENCY-2:0];
    end
  endgenerate

endmodule

// File: rtl/mem_master.sv
// Initiator for the 16-bit main-memory port. Takes single-word writes and
// 1..256-word read bursts on a valid/ready request channel, issues one read
// address per cycle, and returns read data in order on a response channel
// with no backpressure. Out-of-range requests get a single error beat and
// never touch memory.
// Ports:
//   clock, reset                       - system clock, sync active-high reset
//   req_valid/req_ready                - request handshake (ready iff IDLE)
//   req_write/req_addr/req_wdata/req_len - request fields (len = words-1)
//   resp_valid/resp_data/resp_last/resp_err - response beats
//   mem_address/mem_data_in/mem_write  - drive the memory
//   mem_val                            - registered read data from memory
module mem_master
  import mem_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [LEN_W-1:0]  req_len,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_last,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_val
);

  logic [2:0]        state_reg;
  logic [2:0]        state_next;
  logic              ready_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              mem_write_reg;
  logic [LEN_W-1:0]  count_reg;
  logic              ack_valid_reg;
  logic              ack_err_reg;

  logic accept;
  logic req_err;
  logic pipe_in_valid;
  logic pipe_in_last;
  logic pipe_valid;
  logic pipe_last;
  logic pipe_empty;

  assign accept  = req_valid & ready_reg;
  assign req_err = range_err(req_write, req_addr, req_len);

  // One tag per read address presented; count_reg holds words still to issue
  // after the current one, so zero marks the final address of the burst.
  assign pipe_in_valid = (state_reg == READ);
  assign pipe_in_last  = (count_reg == '0);

  mem_rd_pipe u_rd_pipe (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (pipe_in_valid),
    .in_last   (pipe_in_last),
    .out_valid (pipe_valid),
    .out_last  (pipe_last),
    .empty     (pipe_empty)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (req_err)        state_next = ERR;
          else if (req_write) state_next = WRITE;
          else                state_next = READ;
        end
      end
      WRITE:   state_next = IDLE;
      ERR:     state_next = IDLE;
      // The final address always leaves at least one beat in flight.
      READ:    if (count_reg == '0) state_next = DRAIN;
      DRAIN:   if (pipe_empty) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      ready_reg     <= 1'b1;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      mem_write_reg <= 1'b0;
      count_reg     <= '0;
      ack_valid_reg <= 1'b0;
      ack_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ready_reg     <= (state_next == IDLE);
      mem_write_reg <= 1'b0;
      ack_valid_reg <= 1'b0;
      ack_err_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (req_err) begin
              // Error ack only; memory-side registers are left untouched.
              ack_valid_reg <= 1'b1;
              ack_err_reg   <= 1'b1;
            end else if (req_write) begin
              addr_reg      <= req_addr;
              wdata_reg     <= req_wdata;
              mem_write_reg <= 1'b1;
              ack_valid_reg <= 1'b1;
            end else begin
              addr_reg  <= req_addr;
              count_reg <= req_len;
            end
          end
        end
        READ: begin
          if (count_reg != '0) begin
            addr_reg  <= addr_reg + {{(ADDR_W-1){1'b0}}, 1'b1};
            count_reg <= count_reg - {{(LEN_W-1){1'b0}}, 1'b1};
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready   = ready_reg;
  assign mem_address = addr_reg;
  assign mem_data_in = wdata_reg;
  assign mem_write   = mem_write_reg;

  // Write/error acks and read beats never overlap: acks leave IDLE for one
  // cycle only, while read beats start a cycle after READ is entered.
  assign resp_valid = ack_valid_reg | pipe_valid;
  assign resp_last  = ack_valid_reg | pipe_last;
  assign resp_err   = ack_err_reg;
  assign resp_data  = pipe_valid ? mem_val : '0;

endmodule

// File: tb/tb_mem_master.sv
// Testbench for mem_master paired with a behavioural registered-read memory
// preloaded with mem[k] = k ^ 16'hA5A5.
module tb_mem_master;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [7:0]  req_len;
  logic        resp_valid;
  logic [15:0] resp_data;
  logic        resp_last;
  logic        resp_err;
  logic [15:0] mem_address;
  logic [15:0] mem_data_in;
  logic        mem_write;
  logic [15:0] mem_val;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [15:0] mem_array [0:511];
  logic [15:0] model_mem [0:511];

  mem_master dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_len     (req_len),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .resp_last   (resp_last),
    .resp_err    (resp_err),
    .mem_address (mem_address),
    .mem_data_in (mem_data_in),
    .mem_write   (mem_write),
    .mem_val     (mem_val)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural memory: registered read, read-before-write.
  initial begin
    for (int k = 0; k < 512; k++) mem_array[k] = 16'(k) ^ 16'hA5A5;
  end
  always @(posedge clock) begin
    if (mem_write) mem_array[mem_address[8:0]] <= mem_data_in;
    if (reset) mem_val <= 16'h0000;
    else       mem_val <= mem_array[mem_address[8:0]];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  typedef struct {
    string       nm;
    logic        w;
    logic [15:0] a;
    logic [15:0] d;
    logic [7:0]  l;
    logic        exp_err;
    logic [15:0] exp_d0;
  } vec_t;

  vec_t vecs [15];

  // Issue one request and check every cycle until req_ready returns.
  task automatic run_req(input vec_t v);
    int nb;
    int first;
    int rdy_cyc;
    int wr_seen;
    int beat;
    int waitc;
    logic exp_v;
    logic [15:0] expd;
    logic [15:0] addr_before;
    nb      = (v.w || v.exp_err) ? 1 : int'(v.l) + 1;
    first   = (v.w || v.exp_err) ? 1 : 2;
    rdy_cyc = (v.w || v.exp_err) ? 2 : nb + 2;
    waitc = 0;
    @(negedge clock);
    while (!req_ready && waitc < 50) begin
      @(negedge clock);
      waitc++;
    end
    chk({v.nm, " ready_before"}, 32'(req_ready), 32'd1);
    addr_before = mem_address;
    req_valid = 1'b1;
    req_write = v.w;
    req_addr  = v.a;
    req_wdata = v.d;
    req_len   = v.l;
    @(posedge clock);
    #1 req_valid = 1'b0;
    wr_seen = 0;
    beat    = 0;
    for (int k = 1; k <= rdy_cyc; k++) begin
      @(negedge clock);
      exp_v = (k >= first) && (k < first + nb);
      if (mem_write) wr_seen++;
      chk($sformatf("%s valid c%0d", v.nm, k), 32'(resp_valid), 32'(exp_v));
      if (exp_v) begin
        if (k == first) expd = v.exp_d0;
        else            expd = model_mem[v.a[8:0] + 9'(beat)];
        chk($sformatf("%s data b%0d", v.nm, beat), 32'(resp_data), 32'(expd));
        chk($sformatf("%s last b%0d", v.nm, beat), 32'(resp_last), 32'(beat == nb - 1));
        chk($sformatf("%s err b%0d", v.nm, beat), 32'(resp_err), 32'(v.exp_err));
        beat++;
      end else begin
        chk($sformatf("%s idle flags c%0d", v.nm, k), {30'd0, resp_last, resp_err}, 32'd0);
      end
      chk($sformatf("%s ready c%0d", v.nm, k), 32'(req_ready), 32'(k == rdy_cyc));
      if (k == 1 && v.w && !v.exp_err)
        chk({v.nm, " mem addr/data"}, {mem_address, mem_data_in}, {v.a, v.d});
      if (k == 1 && v.exp_err)
        chk({v.nm, " mem addr held"}, 32'(mem_address), 32'(addr_before));
    end
    chk({v.nm, " mem_write cycles"}, 32'(wr_seen), 32'(v.w && !v.exp_err));
    if (v.w && !v.exp_err) model_mem[v.a[8:0]] = v.d;
  endtask

  initial begin
    for (int k = 0; k < 512; k++) model_mem[k] = 16'(k) ^ 16'hA5A5;
    vecs[0]  = '{"rd5",       1'b0, 16'd5,    16'h0000, 8'd0,   1'b0, 16'hA5A0};
    vecs[1]  = '{"wr10",      1'b1, 16'd10,   16'h1234, 8'd0,   1'b0, 16'h0000};
    vecs[2]  = '{"rd10",      1'b0, 16'd10,   16'h0000, 8'd0,   1'b0, 16'h1234};
    vecs[3]  = '{"rd508x4",   1'b0, 16'd508,  16'h0000, 8'd3,   1'b0, 16'hA459};
    vecs[4]  = '{"rd508x5",   1'b0, 16'd508,  16'h0000, 8'd4,   1'b1, 16'h0000};
    vecs[5]  = '{"wr512",     1'b1, 16'd512,  16'hDEAD, 8'd0,   1'b1, 16'h0000};
    vecs[6]  = '{"rd511",     1'b0, 16'd511,  16'h0000, 8'd0,   1'b0, 16'hA45A};
    vecs[7]  = '{"rd0x256",   1'b0, 16'd0,    16'h0000, 8'd255, 1'b0, 16'hA5A5};
    vecs[8]  = '{"rd256x256", 1'b0, 16'd256,  16'h0000, 8'd255, 1'b0, 16'hA4A5};
    vecs[9]  = '{"rd257x256", 1'b0, 16'd257,  16'h0000, 8'd255, 1'b1, 16'h0000};
    vecs[10] = '{"rd600",     1'b0, 16'd600,  16'h0000, 8'd0,   1'b1, 16'h0000};
    vecs[11] = '{"wr511",     1'b1, 16'd511,  16'hBEEF, 8'd0,   1'b0, 16'h0000};
    vecs[12] = '{"rd510x2",   1'b0, 16'd510,  16'h0000, 8'd1,   1'b0, 16'hA45B};
    vecs[13] = '{"wrFFFF",    1'b1, 16'hFFFF, 16'h0001, 8'd0,   1'b1, 16'h0000};
    vecs[14] = '{"rd511x256", 1'b0, 16'd511,  16'h0000, 8'd255, 1'b1, 16'h0000};

    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_len   = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("reset ready", 32'(req_ready), 32'd1);
    chk("reset resp", {13'd0, resp_valid, resp_last, resp_err, resp_data}, 32'd0);
    chk("reset mem", {mem_address, mem_data_in}, 32'd0);
    chk("reset mem_write", 32'(mem_write), 32'd0);

    for (int i = 0; i < 15; i++) begin
      run_req(vecs[i]);
      $display("txn %s w=%0b addr=%0h len=%0d done, checks %0d/%0d", vecs[i].nm,
               vecs[i].w, vecs[i].a, vecs[i].l, pass_cnt, total_cnt);
    end

    // req_valid held through a burst: second request accepted right after the last beat.
    @(negedge clock);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 16'd20;
    req_len   = 8'd3;
    @(posedge clock);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      chk($sformatf("hold ready c%0d", k), 32'(req_ready), 32'(k == 6));
      chk($sformatf("hold valid c%0d", k), 32'(resp_valid), 32'(k >= 2 && k <= 5));
      if (k >= 2 && k <= 5)
        chk($sformatf("hold data c%0d", k), 32'(resp_data), 32'(model_mem[20 + k - 2]));
    end
    @(posedge clock);
    #1 req_valid = 1'b0;
    for (int k = 7; k <= 12; k++) begin
      @(negedge clock);
      chk($sformatf("hold2 ready c%0d", k), 32'(req_ready), 32'(k == 12));
      chk($sformatf("hold2 valid c%0d", k), 32'(resp_valid), 32'(k >= 8 && k <= 11));
      if (k >= 8 && k <= 11)
        chk($sformatf("hold2 data c%0d", k), 32'(resp_data), 32'(model_mem[20 + k - 8]));
    end
    $display("txn hold-valid back-to-back bursts done, checks %0d/%0d", pass_cnt, total_cnt);

    // Reset asserted during beat 2 of an 8-word burst.
    @(negedge clock);
    req_valid = 1'b1;
    req_addr  = 16'd40;
    req_len   = 8'd7;
    @(posedge clock);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 3; k++) @(negedge clock);
    chk("rst beat2 valid", 32'(resp_valid), 32'd1);
    chk("rst beat2 data", 32'(resp_data), 32'(model_mem[41]));
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst after ready", 32'(req_ready), 32'd1);
    chk("rst after resp", {13'd0, resp_valid, resp_last, resp_err, resp_data}, 32'd0);
    chk("rst after mem", {mem_address, mem_data_in}, 32'd0);
    chk("rst after mem_write", 32'(mem_write), 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      chk($sformatf("rst quiet c%0d", k), 32'(resp_valid), 32'd0);
    end
    run_req('{"rd40 post-reset", 1'b0, 16'd40, 16'h0000, 8'd0, 1'b0, 16'hA58D});
    $display("txn reset mid-burst then fresh read done, checks %0d/%0d", pass_cnt, total_cnt);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
